// File: rtl/m2_pkg.sv
// Shared types and constants for the M2 block writer.
// Holds the FSM state enum, the colour segment enum, SRAM bases, row widths and the address helper.
package m2_pkg;

    typedef enum logic [2:0] {
        S_WB_IDLE,
        S_WB_LEAD_IN,
        S_WB_FETCH,
        S_WB_WRITE,
        S_WB_DONE
    } wb_state_t;

    typedef enum logic [1:0] {
        SEG_Y   = 2'd0,
        SEG_U   = 2'd1,
        SEG_V   = 2'd2,
        SEG_BAD = 2'd3
    } seg_t;

    localparam logic [17:0] BASE_Y   = 18'd0;
    localparam logic [17:0] BASE_U   = 18'd38400;
    localparam logic [17:0] BASE_V   = 18'd57600;
    localparam logic [17:0] ROW_W_Y  = 18'd160;
    localparam logic [17:0] ROW_W_UV = 18'd80;

    // A request is legal only inside the picture of its own segment.
    function automatic logic req_ok(input seg_t seg,
                                    input logic [4:0] row,
                                    input logic [5:0] col);
        logic [5:0] col_max;
        col_max = (seg == SEG_Y) ? 6'd39 : 6'd19;
        return (seg != SEG_BAD) && (row <= 5'd29) && (col <= col_max);
    endfunction

    // Word k covers pixel row k[4:2], pixel pair k[1:0] of the 8x8 block.
    function automatic logic [17:0] block_addr(input seg_t seg,
                                               input logic [4:0] row,
                                               input logic [5:0] col,
                                               input logic [4:0] k);
        logic [17:0] base;
        logic [17:0] width;
        logic [17:0] line;
        base  = (seg == SEG_Y) ? BASE_Y :
                (seg == SEG_U) ? BASE_U : BASE_V;
        width = (seg == SEG_Y) ? ROW_W_Y : ROW_W_UV;
        line  = {10'd0, row, 3'd0} + {15'd0, k[4:2]};
        return base + line * width + {10'd0, col, 2'd0} + {16'd0, k[1:0]};
    endfunction

endpackage

// File: rtl/m2_block_writer_clip.sv
// Saturates a signed 32-bit IDCT result to an 8-bit pixel.
// Ports: value (signed 32-bit in), pixel (unsigned 8-bit out).
module pixel_clip (
    input  logic signed [31:0] value,
    output logic        [7:0]  pixel
);

    always_comb begin
        pixel = value[7:0];
        if (value[31])
            pixel = 8'd0;
        else if (|value[30:8])
            pixel = 8'hFF;
    end

endmodule

// File: rtl/m2_block_writer.sv
// Writes one 8x8 IDCT result block from the dual-port RAM into SRAM, two pixels per word.
// Ports: clock/reset, WB_* request/finish, DP_* RAM read side, M2_SRAM_* registered write side.
module m2_block_writer
    import m2_pkg::*;
(
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        WB_start,
    input  logic [4:0]  WB_block_row,
    input  logic [5:0]  WB_block_col,
    input  logic [1:0]  WB_segment,
    output logic        WB_finish,
    output logic        WB_error,
    output logic [5:0]  DP_address_a,
    output logic [5:0]  DP_address_b,
    input  logic [31:0] DP_read_data_a,
    input  logic [31:0] DP_read_data_b,
    output logic [17:0] M2_SRAM_address,
    output logic        M2_SRAM_we_n,
    output logic [15:0] M2_SRAM_write_data
);

    wb_state_t   state;
    logic [4:0]  row_q;
    logic [5:0]  col_q;
    seg_t        seg_q;
    logic [5:0]  fetch_k;
    logic [4:0]  write_k;

    logic [7:0]  pix_a;
    logic [7:0]  pix_b;
    logic [4:0]  next_k;
    logic [17:0] wr_addr;
    logic        fetching;

    pixel_clip u_clip_a (.value(DP_read_data_a), .pixel(pix_a));
    pixel_clip u_clip_b (.value(DP_read_data_b), .pixel(pix_b));

    // RAM data lags its address by one cycle, so the write index trails fetch.
    always_comb begin
        next_k   = (state == S_WB_FETCH) ? 5'd0 : write_k + 5'd1;
        wr_addr  = block_addr(seg_q, row_q, col_q, next_k);
        fetching = (state == S_WB_LEAD_IN || state == S_WB_FETCH ||
                    state == S_WB_WRITE) && !fetch_k[5];
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state              <= S_WB_IDLE;
            row_q              <= 5'd0;
            col_q              <= 6'd0;
            seg_q              <= SEG_Y;
            fetch_k            <= 6'd0;
            write_k            <= 5'd0;
            WB_finish          <= 1'b0;
            WB_error           <= 1'b0;
            DP_address_a       <= 6'd0;
            DP_address_b       <= 6'd0;
            M2_SRAM_address    <= 18'd0;
            M2_SRAM_we_n       <= 1'b1;
            M2_SRAM_write_data <= 16'd0;
        end else begin
            WB_finish <= 1'b0;
            WB_error  <= 1'b0;

            if (fetching) begin
                DP_address_a <= {fetch_k[4:0], 1'b0};
                DP_address_b <= {fetch_k[4:0], 1'b1};
                fetch_k      <= fetch_k + 6'd1;
            end else begin
                DP_address_a <= 6'd0;
                DP_address_b <= 6'd0;
            end

            unique case (state)
                S_WB_IDLE: begin
                    if (WB_start) begin
                        row_q <= WB_block_row;
                        col_q <= WB_block_col;
                        seg_q <= seg_t'(WB_segment);
                        if (req_ok(seg_t'(WB_segment), WB_block_row,
                                   WB_block_col)) begin
                            state        <= S_WB_LEAD_IN;
                            DP_address_a <= 6'd0;
                            DP_address_b <= 6'd1;
                            fetch_k      <= 6'd1;
                        end else begin
                            state     <= S_WB_DONE;
                            WB_finish <= 1'b1;
                            WB_error  <= 1'b1;
                        end
                    end
                end
                S_WB_LEAD_IN: begin
                    state <= S_WB_FETCH;
                end
                S_WB_FETCH: begin
                    M2_SRAM_we_n       <= 1'b0;
                    M2_SRAM_address    <= wr_addr;
                    M2_SRAM_write_data <= {pix_a, pix_b};
                    write_k            <= 5'd0;
                    state              <= S_WB_WRITE;
                end
                S_WB_WRITE: begin
                    if (write_k == 5'd31) begin
                        M2_SRAM_we_n       <= 1'b1;
                        M2_SRAM_address    <= 18'd0;
                        M2_SRAM_write_data <= 16'd0;
                        WB_finish          <= 1'b1;
                        state              <= S_WB_DONE;
                    end else begin
                        M2_SRAM_address    <= wr_addr;
                        M2_SRAM_write_data <= {pix_a, pix_b};
                        write_k            <= next_k;
                    end
                end
                S_WB_DONE: begin
                    state <= S_WB_IDLE;
                end
                default: begin
                    state <= S_WB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m2_block_writer.sv
// Scoreboard bench for m2_block_writer: directed cases plus randomized blocks.
// A behavioural model pushes expected SRAM writes and finish pulses; a negedge monitor checks them.
module tb_m2_block_writer;

    typedef struct {
        int          cyc;
        logic [17:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int   cyc;
        logic err;
    } fin_t;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        WB_start;
    logic [4:0]  WB_block_row;
    logic [5:0]  WB_block_col;
    logic [1:0]  WB_segment;
    logic        WB_finish;
    logic        WB_error;
    logic [5:0]  DP_address_a;
    logic [5:0]  DP_address_b;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic [17:0] M2_SRAM_address;
    logic        M2_SRAM_we_n;
    logic [15:0] M2_SRAM_write_data;

    logic signed [31:0] ram [64];
    wr_t  wq[$];
    fin_t fq[$];
    int   cyc   = 0;
    int   act_t = -1000;
    int   tests = 0;
    int   fails = 0;

    m2_block_writer dut (
        .CLOCK_50_I         (clk),
        .Resetn             (Resetn),
        .WB_start           (WB_start),
        .WB_block_row       (WB_block_row),
        .WB_block_col       (WB_block_col),
        .WB_segment         (WB_segment),
        .WB_finish          (WB_finish),
        .WB_error           (WB_error),
        .DP_address_a       (DP_address_a),
        .DP_address_b       (DP_address_b),
        .DP_read_data_a     (rd_a),
        .DP_read_data_b     (rd_b),
        .M2_SRAM_address    (M2_SRAM_address),
        .M2_SRAM_we_n       (M2_SRAM_we_n),
        .M2_SRAM_write_data (M2_SRAM_write_data)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rd_a <= ram[DP_address_a];
        rd_b <= ram[DP_address_b];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] clip(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'hFF;
        return v[7:0];
    endfunction

    task automatic model(input int t, input int row, input int col,
                         input int seg);
        int base;
        int w;
        int a;
        bit ok;
        ok = (seg != 3) && (row <= 29) && (col <= ((seg == 0) ? 39 : 19));
        if (!ok) begin
            fq.push_back('{t + 1, 1'b1});
            return;
        end
        base  = (seg == 0) ? 0 : (seg == 1) ? 38400 : 57600;
        w     = (seg == 0) ? 160 : 80;
        act_t = t;
        for (int k = 0; k < 32; k++) begin
            a = base + (row * 8 + k / 4) * w + col * 4 + k % 4;
            wq.push_back('{t + 3 + k, a[17:0],
                           {clip(ram[2*k]), clip(ram[2*k+1])}});
        end
        fq.push_back('{t + 35, 1'b0});
    endtask

    // Caller is at posedge+1; returns one cycle later at posedge+1.
    task automatic issue(input int row, input int col, input int seg,
                         input bit push);
        WB_block_row = row[4:0];
        WB_block_col = col[5:0];
        WB_segment   = seg[1:0];
        WB_start     = 1'b1;
        if (push) model(cyc, row, col, seg);
        @(posedge clk);
        #1;
        WB_start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && (wq.size() != 0 || fq.size() != 0); i++)
            @(posedge clk);
        #1;
        if (wq.size() != 0 || fq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: writes left %0d finish left %0d",
                     wq.size(), fq.size());
            wq.delete();
            fq.delete();
        end
    endtask

    always @(negedge clk) begin
        if (Resetn === 1'b1) begin
            int ea;
            wr_t  w;
            fin_t f;
            ea = (cyc >= act_t + 1 && cyc <= act_t + 32) ?
                 2 * (cyc - act_t - 1) : 0;
            chk("dp_addr_a", {26'd0, DP_address_a}, ea);
            chk("dp_addr_b", {26'd0, DP_address_b},
                (ea == 0 && cyc != act_t + 1) ? 0 : ea + 1);
            if (M2_SRAM_we_n === 1'b0) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr %0d data %0h",
                             M2_SRAM_address, M2_SRAM_write_data);
                end else begin
                    w = wq.pop_front();
                    chk("wr_cycle", cyc, w.cyc);
                    chk("wr_addr", {14'd0, M2_SRAM_address}, {14'd0, w.addr});
                    chk("wr_data", {16'd0, M2_SRAM_write_data}, {16'd0, w.data});
                end
            end else if (M2_SRAM_write_data !== 16'd0) begin
                chk("idle_data", {16'd0, M2_SRAM_write_data}, 0);
            end
            if (WB_finish === 1'b1) begin
                if (fq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_finish: err %0b", WB_error);
                end else begin
                    f = fq.pop_front();
                    chk("fin_cycle", cyc, f.cyc);
                    chk("fin_error", {31'd0, WB_error}, {31'd0, f.err});
                end
            end else if (WB_error !== 1'b0) begin
                chk("error_alone", {31'd0, WB_error}, 0);
            end
        end
    end

    initial begin
        int row;
        int col;
        int seg;
        int r;
        Resetn       = 1'b0;
        WB_start     = 1'b0;
        WB_block_row = 5'd0;
        WB_block_col = 6'd0;
        WB_segment   = 2'd0;
        for (int i = 0; i < 64; i++) ram[i] = i;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we_n", {31'd0, M2_SRAM_we_n}, 1);
        chk("rst_addr", {14'd0, M2_SRAM_address}, 0);
        chk("rst_finish", {30'd0, WB_finish, WB_error}, 0);
        chk("rst_dp", {20'd0, DP_address_a, DP_address_b}, 0);
        Resetn = 1'b1;
        @(posedge clk);
        #1;

        // Y block at origin with ramp RAM contents
        issue(0, 0, 0, 1);
        wait_drain();

        // V block in the last row/col, every value saturates high
        for (int i = 0; i < 64; i++) ram[i] = 300;
        issue(29, 19, 2, 1);
        wait_drain();

        // U block, negative clips to zero, 128 passes through
        for (int i = 0; i < 64; i++) ram[i] = int'($urandom_range(0, 400)) - 100;
        ram[0] = -7;
        ram[1] = 128;
        issue(5, 3, 1, 1);
        wait_drain();

        // Out-of-range column is rejected
        issue(0, 40, 0, 1);
        wait_drain();

        // Start during a block is ignored; back-to-back start is accepted
        issue(2, 7, 0, 1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        issue(3, 3, 1, 0);
        wait_drain();
        issue(4, 10, 2, 1);
        wait_drain();

        // Reset mid-block abandons it
        issue(1, 1, 0, 1);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        Resetn = 1'b0;
        #1;
        chk("midrst_we_n", {31'd0, M2_SRAM_we_n}, 1);
        chk("midrst_data", {16'd0, M2_SRAM_write_data}, 0);
        chk("midrst_dp", {20'd0, DP_address_a, DP_address_b}, 0);
        wq.delete();
        fq.delete();
        act_t = -1000;
        repeat (2) @(posedge clk);
        #1;
        Resetn = 1'b1;
        repeat (45) @(posedge clk);
        #1;

        // Randomized blocks, some illegal
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 7) == 0) ram[i] = $urandom;
                else ram[i] = int'($urandom_range(0, 600)) - 200;
            end
            seg = $urandom_range(0, 2);
            row = $urandom_range(0, 29);
            col = $urandom_range(0, (seg == 0) ? 39 : 19);
            r   = $urandom_range(0, 9);
            if (r == 0) seg = 3;
            if (r == 1) row = $urandom_range(30, 31);
            if (r == 2) col = $urandom_range((seg == 0) ? 40 : 20, 63);
            issue(row, col, seg, 1);
            wait_drain();
        end

        chk("final_wq", wq.size(), 0);
        chk("final_fq", fq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/m2_block_writer.md
M2_BLOCK_WRITER -- requirements
Module: m2_block_writer

Interface
REQ-001 SHALL have port CLOCK_50_I, input, 1: sole clock, 50 MHz, all state on rising edge.
REQ-002 SHALL have port Resetn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port WB_start, input, 1: one-cycle request to write back one 8x8 block.
REQ-004 SHALL have port WB_block_row, input, 5: block row, 0..29.
REQ-005 SHALL have port WB_block_col, input, 6: block column, 0..39 for Y, 0..19 for U/V.
REQ-006 SHALL have port WB_segment, input, 2: 0=Y, 1=U, 2=V, 3=illegal.
REQ-007 SHALL have port WB_finish, output, 1: one-cycle completion pulse.
REQ-008 SHALL have port WB_error, output, 1: one-cycle pulse, coincident with WB_finish, when the request was rejected.
REQ-009 SHALL have ports DP_address_a and DP_address_b, output, 6 each: read addresses into the IDCT result dual-port RAM, which holds 64 row-major entries.
REQ-010 SHALL have ports DP_read_data_a and DP_read_data_b, input, 32 each: signed IDCT results, valid one cycle after the address is presented.
REQ-011 SHALL have ports M2_SRAM_address (output, 18), M2_SRAM_we_n (output, 1) and M2_SRAM_write_data (output, 16), all registered.

Function
REQ-012 SHALL use states S_WB_IDLE, S_WB_LEAD_IN, S_WB_FETCH, S_WB_WRITE, S_WB_DONE.
REQ-013 SHALL, in S_WB_IDLE with WB_start=1 at cycle T, latch row, col and segment, then go to S_WB_LEAD_IN.
REQ-014 SHALL drive DP_address_a=2k and DP_address_b=2k+1 for k=0..31, presenting k=0 at T+1.
REQ-015 SHALL, for each k, clip each 32-bit signed value to 0..255 (negative->0, >255->255) and pack the pair as {clip(a)[7:0], clip(b)[7:0]}.
REQ-016 SHALL write word k at cycle T+3+k with M2_SRAM_we_n=0, producing exactly 32 writes at one write per cycle with no bubbles.
REQ-017 SHALL compute address = base + (row*8 + k[4:2])*W + col*4 + k[1:0], with base Y=0, U=38400, V=57600, and W=160 for Y or 80 for U/V; all arithmetic 18-bit unsigned.
REQ-018 SHALL pulse WB_finish at T+35, with M2_SRAM_we_n=1 from T+35 onward; start-to-finish is 35 cycles.
REQ-019 SHALL ignore WB_start outside S_WB_IDLE.
REQ-020 SHALL reject a request with segment=3, col above the segment maximum, or row>29: no SRAM write occurs, and WB_finish and WB_error pulse at T+1.
REQ-021 SHALL hold M2_SRAM_we_n=1, M2_SRAM_write_data=0 and the DP addresses at 0 in all cycles other than those defined in REQ-014 and REQ-016.
REQ-022 SHALL accept WB_start in the cycle immediately after WB_finish.

Reset
REQ-023 SHALL, while Resetn=0, force state to S_WB_IDLE, M2_SRAM_we_n=1, and all other outputs and counters to 0, asynchronously.
REQ-024 SHALL abandon a block interrupted by reset mid-operation, with no further writes and no finish pulse after reset release.

Structure
REQ-025 SHALL place the state enum, the segment enum, the base addresses (0, 38400, 57600) and the row widths (160, 80) in shared package m2_pkg.
REQ-026 SHALL instantiate sub-module pixel_clip (32-bit signed in, 8-bit unsigned out) twice, once per RAM port.

Verification
REQ-027 SHALL cover: Y, row 0, col 0, RAM[i]=i -> 32 writes at T+3..T+34 to addresses 0..3, 160..163, ..., 1120..1123; first data 16'h0001; WB_finish at T+35.
REQ-028 SHALL cover: V, row 29, col 19, RAM all 300 -> addresses 57600+(232+r)*80+76..79; every data word 16'hFFFF.
REQ-029 SHALL cover: U, row 5, col 3, RAM[0]=-7 and RAM[1]=128 -> first write at address 38400+3200+12=41612, data 16'h0080.
REQ-030 SHALL cover: Y, col 40 -> no write; WB_finish and WB_error at T+1.
REQ-031 SHALL cover: Resetn low at T+10 -> M2_SRAM_we_n=1 immediately; no writes and no WB_finish after release.
REQ-032 SHALL cover: WB_start pulsed at T+5 during a block -> ignored, exactly 32 writes; a new start at T+36 is accepted.
